// File: rtl/tinyalu_pkg.sv
// tinyalu_pkg: shared types for the TinyALU and its requester arbiter.
//   operation_t        - TinyALU opcode encoding
//   arb_state_t        - arbiter FSM states
//   ARB_TIMEOUT_RESULT - result returned when the ALU never signals done
//   is_alu_op()        - true for opcodes that must run on the ALU
package tinyalu_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_t;

    localparam logic [15:0] ARB_TIMEOUT_RESULT = 16'hDEAD;

    // Unused encodings (3'b101, 3'b110) fall into the default and complete locally.
    function automatic logic is_alu_op(operation_t op);
        logic r;
        case (op)
            add_op, and_op, xor_op, mul_op: r = 1'b1;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tinyalu_rr_arbiter.sv
// tinyalu_rr_arbiter: combinational round-robin pick.
//   req_i        - request vector
//   last_grant_i - index granted most recently; search starts just above it
//   any_valid_o  - at least one request is set
//   winner_o     - first set index searching upward from last_grant_i+1, wrapping
module tinyalu_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     last_grant_i,
    output logic               any_valid_o,
    output logic [IDW-1:0]     winner_o
);

    logic [IDW-1:0] idx;

    always_comb begin
        any_valid_o = 1'b0;
        winner_o    = '0;
        idx         = '0;
        // Offset 1..NUM_REQ visits every index once, ending at last_grant itself.
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = IDW'((32'(last_grant_i) + i) % NUM_REQ);
            if (!any_valid_o && req_i[idx]) begin
                any_valid_o = 1'b1;
                winner_o    = idx;
            end
        end
    end

endmodule

// File: rtl/tinyalu_arbiter.sv
// tinyalu_arbiter: shares one TinyALU between NUM_REQ valid/ready requesters.
//   clk, reset_n             - clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  - per-requester handshake (ready is a one-hot accept strobe)
//   req_a_i/req_b_i/req_op_i - packed per-requester operands and opcode
//   rsp_valid_o              - one-cycle response strobe to the owning requester
//   rsp_result_o/rsp_err_o   - result and timeout flag, valid with rsp_valid_o
//   rsp_id_o                 - index of the responding requester
//   alu_*                    - TinyALU start/op/A/B handshake, done and result
module tinyalu_arbiter
    import tinyalu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 15,
    localparam int unsigned IDW = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    input  logic [NUM_REQ*8-1:0] req_a_i,
    input  logic [NUM_REQ*8-1:0] req_b_i,
    input  logic [NUM_REQ*3-1:0] req_op_i,
    output logic [NUM_REQ-1:0]   rsp_valid_o,
    output logic [15:0]          rsp_result_o,
    output logic                 rsp_err_o,
    output logic [IDW-1:0]       rsp_id_o,
    output logic                 alu_start_o,
    output logic [2:0]           alu_op_o,
    output logic [7:0]           alu_a_o,
    output logic [7:0]           alu_b_o,
    input  logic                 alu_done_i,
    input  logic [15:0]          alu_result_i
);

    // Watchdog counts 0..TIMEOUT-1; the last value is the final EXEC cycle.
    localparam int unsigned    WdW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

    arb_state_t     state_q, state_d;
    logic [IDW-1:0] last_grant_q, last_grant_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [2:0]     op_q, op_d;
    logic [7:0]     a_q, a_d, b_q, b_d;
    logic [15:0]    result_q, result_d;
    logic           err_q, err_d;
    logic [WdW-1:0] wd_q, wd_d;

    logic           any_valid;
    logic [IDW-1:0] winner;
    logic [7:0]     sel_a, sel_b;
    logic [2:0]     sel_op;
    logic           wd_expired;

    tinyalu_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req_i        (req_valid_i),
        .last_grant_i (last_grant_q),
        .any_valid_o  (any_valid),
        .winner_o     (winner)
    );

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (winner == IDW'(i)) begin
                sel_a  = req_a_i[8*i +: 8];
                sel_b  = req_b_i[8*i +: 8];
                sel_op = req_op_i[3*i +: 3];
            end
        end
    end

    assign wd_expired = (wd_q == WdLast);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d = is_alu_op(operation_t'(sel_op)) ? EXEC : RESP;
                end
            end
            EXEC: begin
                if (alu_done_i || wd_expired) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= IDW'(NUM_REQ - 1);
            owner_q      <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
            wd_q         <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            result_q     <= result_d;
            err_q        <= err_d;
            wd_q         <= wd_d;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        err_d        = err_q;
        wd_d         = wd_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    last_grant_d = winner;
                    owner_d      = winner;
                    op_d         = sel_op;
                    a_d          = sel_a;
                    b_d          = sel_b;
                    result_d     = 16'h0000;
                    err_d        = 1'b0;
                    wd_d         = '0;
                end
            end
            EXEC: begin
                wd_d = wd_q + WdW'(1);
                // Done takes priority over the watchdog on the same cycle.
                if (alu_done_i) begin
                    result_d = alu_result_i;
                    err_d    = 1'b0;
                end else if (wd_expired) begin
                    result_d = ARB_TIMEOUT_RESULT;
                    err_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready_o  = '0;
        rsp_valid_o  = '0;
        rsp_result_o = '0;
        rsp_err_o    = 1'b0;
        rsp_id_o     = '0;
        alu_start_o  = 1'b0;
        alu_op_o     = '0;
        alu_a_o      = '0;
        alu_b_o      = '0;
        case (state_q)
            IDLE: begin
                // Gated by reset so the strobe is low while reset is held.
                if (any_valid && reset_n) begin
                    req_ready_o = NUM_REQ'(1) << winner;
                end
            end
            EXEC: begin
                alu_start_o = 1'b1;
                alu_op_o    = op_q;
                alu_a_o     = a_q;
                alu_b_o     = b_q;
            end
            RESP: begin
                rsp_valid_o  = NUM_REQ'(1) << owner_q;
                rsp_result_o = result_q;
                rsp_err_o    = err_q;
                rsp_id_o     = owner_q;
            end
            default: ;
        endcase
    end

    // A requester must hold valid until it is accepted.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_hold
        a_req_hold : assert property (@(posedge clk) disable iff (!reset_n)
            (req_valid_i[g] && !req_ready_o[g]) |=> req_valid_i[g]);
    end

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// tb_tinyalu_arbiter: directed bench for tinyalu_arbiter with a TinyALU model whose
// done latency (cycles after start rises) is set per step.
module tb_tinyalu_arbiter;
    import tinyalu_pkg::*;

    localparam int NUM_REQ = 4;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*8-1:0] req_a;
    logic [NUM_REQ*8-1:0] req_b;
    logic [NUM_REQ*3-1:0] req_op;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [15:0]          rsp_result;
    logic                 rsp_err;
    logic [1:0]           rsp_id;
    logic                 alu_start;
    logic [2:0]           alu_op;
    logic [7:0]           alu_a;
    logic [7:0]           alu_b;
    logic                 alu_done;
    logic [15:0]          alu_result;

    int n_asserts = 0;
    int n_fail    = 0;
    int lat       = 1000;
    int start_cnt = 0;
    logic stray   = 1'b0;

    always #5 clk = ~clk;

    tinyalu_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (15)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_op_i     (req_op),
        .rsp_valid_o  (rsp_valid),
        .rsp_result_o (rsp_result),
        .rsp_err_o    (rsp_err),
        .rsp_id_o     (rsp_id),
        .alu_start_o  (alu_start),
        .alu_op_o     (alu_op),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_done_i   (alu_done),
        .alu_result_i (alu_result)
    );

    // ALU model: start_cnt is 0 in the first start cycle; done when it equals lat.
    always @(posedge clk) start_cnt <= alu_start ? start_cnt + 1 : 0;

    always_comb begin
        alu_done = (alu_start && (start_cnt == lat)) || stray;
        case (alu_op)
            3'b001:  alu_result = {8'h00, alu_a} + {8'h00, alu_b};
            3'b010:  alu_result = {8'h00, alu_a & alu_b};
            3'b011:  alu_result = {8'h00, alu_a ^ alu_b};
            3'b100:  alu_result = 16'(alu_a) * 16'(alu_b);
            default: alu_result = 16'h0000;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] a,
                           input logic [7:0] b, input logic [2:0] op);
        req_valid[i]     = v;
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
        req_op[3*i +: 3] = op;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int exp_i;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;

        // Reset: everything low even with requests pending
        step();
        req_valid = 4'b1111;
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_alu_start", 32'(alu_start), 32'h0);
        chk("rst_rsp_result", 32'(rsp_result), 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        req_valid = '0;
        step();
        reset_n = 1'b1;
        step();

        // Fairness: all requesters hold xor requests; grants 0,1,2,3,0,1,2,3
        lat = 1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 8'(i), 8'h0F, 3'b011);
        #1;
        for (int k = 0; k < 8; k++) begin
            exp_i = k % 4;
            chk("rr_ready", 32'(req_ready), 32'(1) << exp_i);
            step();
            if (k >= 4) req_valid[exp_i] = 1'b0;
            chk("rr_alu_a", 32'(alu_a), 32'(exp_i));
            step();
            step();
            chk("rr_rsp_valid", 32'(rsp_valid), 32'(1) << exp_i);
            chk("rr_rsp_id", 32'(rsp_id), 32'(exp_i));
            chk("rr_rsp_result", 32'(rsp_result), 32'(exp_i ^ 8'h0F));
            chk("rr_ready_in_resp", 32'(req_ready), 32'h0);
            step();
        end

        // Req0 add 3+5, done one cycle after start
        lat = 1;
        set_req(0, 1'b1, 8'h03, 8'h05, 3'b001);
        #1;
        chk("add_ready", 32'(req_ready), 32'h1);
        step();
        req_valid[0] = 1'b0;
        chk("add_start_t1", 32'(alu_start), 32'h1);
        chk("add_op", 32'(alu_op), 32'h1);
        chk("add_a", 32'(alu_a), 32'h03);
        chk("add_b", 32'(alu_b), 32'h05);
        step();
        chk("add_start_t2", 32'(alu_start), 32'h1);
        chk("add_no_early_rsp", 32'(rsp_valid), 32'h0);
        step();
        chk("add_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("add_result", 32'(rsp_result), 32'h0008);
        chk("add_err", 32'(rsp_err), 32'h0);
        chk("add_start_resp", 32'(alu_start), 32'h0);
        step();
        chk("add_rsp_one_cycle", 32'(rsp_valid), 32'h0);

        // Req2 mul FF*FF, done three cycles after start
        lat = 3;
        set_req(2, 1'b1, 8'hFF, 8'hFF, 3'b100);
        #1;
        chk("mul_ready", 32'(req_ready), 32'h4);
        step();
        req_valid[2] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk("mul_start", 32'(alu_start), 32'h1);
            chk("mul_op_stable", 32'({alu_op, alu_a, alu_b}), 32'({3'b100, 8'hFF, 8'hFF}));
            step();
        end
        chk("mul_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("mul_rsp_id", 32'(rsp_id), 32'h2);
        chk("mul_result", 32'(rsp_result), 32'hFE01);
        chk("mul_start_resp", 32'(alu_start), 32'h0);
        step();

        // Local opcodes: no_op on req1, unused 3'b110 on req3
        set_req(1, 1'b1, 8'h12, 8'h34, 3'b000);
        #1;
        chk("nop_ready", 32'(req_ready), 32'h2);
        step();
        req_valid[1] = 1'b0;
        chk("nop_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("nop_result", 32'(rsp_result), 32'h0);
        chk("nop_no_start", 32'(alu_start), 32'h0);
        step();
        set_req(3, 1'b1, 8'h56, 8'h78, 3'b110);
        #1;
        chk("op6_ready", 32'(req_ready), 32'h8);
        step();
        req_valid[3] = 1'b0;
        chk("op6_rsp_valid", 32'(rsp_valid), 32'h8);
        chk("op6_result", 32'(rsp_result), 32'h0);
        chk("op6_no_start", 32'(alu_start), 32'h0);
        step();

        // Timeout: and_op on req0, ALU never answers
        lat = 1000;
        set_req(0, 1'b1, 8'hAA, 8'h0F, 3'b010);
        #1;
        chk("to_ready", 32'(req_ready), 32'h1);
        step();
        req_valid[0] = 1'b0;
        repeat (14) step();
        chk("to_start_last_exec", 32'(alu_start), 32'h1);
        chk("to_no_rsp_yet", 32'(rsp_valid), 32'h0);
        step();
        chk("to_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("to_result", 32'(rsp_result), 32'hDEAD);
        chk("to_err", 32'(rsp_err), 32'h1);
        chk("to_start_resp", 32'(alu_start), 32'h0);
        step();

        // Next request after a timeout completes normally
        lat = 1;
        set_req(1, 1'b1, 8'h10, 8'h20, 3'b001);
        #1;
        chk("post_to_ready", 32'(req_ready), 32'h2);
        step();
        req_valid[1] = 1'b0;
        step();
        step();
        chk("post_to_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("post_to_result", 32'(rsp_result), 32'h0030);
        chk("post_to_err", 32'(rsp_err), 32'h0);
        step();

        // Done on the same cycle the watchdog expires: done wins
        lat = 14;
        set_req(2, 1'b1, 8'h05, 8'h03, 3'b011);
        #1;
        chk("edge_ready", 32'(req_ready), 32'h4);
        step();
        req_valid[2] = 1'b0;
        repeat (15) step();
        chk("edge_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("edge_result", 32'(rsp_result), 32'h0006);
        chk("edge_err", 32'(rsp_err), 32'h0);
        step();

        // Stray done while idle is ignored
        stray = 1'b1;
        step();
        stray = 1'b0;
        chk("stray_rsp", 32'(rsp_valid), 32'h0);
        chk("stray_start", 32'(alu_start), 32'h0);

        // Reset mid-EXEC abandons the operation
        lat = 1000;
        set_req(1, 1'b1, 8'h01, 8'h02, 3'b001);
        #1;
        chk("rmid_ready", 32'(req_ready), 32'h2);
        step();
        req_valid[1] = 1'b0;
        step();
        chk("rmid_start_before", 32'(alu_start), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("rmid_start_async", 32'(alu_start), 32'h0);
        step();
        chk("rmid_no_rsp0", 32'(rsp_valid), 32'h0);
        step();
        reset_n = 1'b1;
        step();
        chk("rmid_no_rsp1", 32'(rsp_valid), 32'h0);

        // After reset the pointer restarts: req0 beats req3, then req3
        lat = 1;
        set_req(0, 1'b1, 8'h07, 8'h08, 3'b001);
        set_req(3, 1'b1, 8'h09, 8'h09, 3'b001);
        #1;
        chk("rmid_first_grant", 32'(req_ready), 32'h1);
        step();
        req_valid[0] = 1'b0;
        step();
        step();
        chk("rmid_rsp0_id", 32'(rsp_id), 32'h0);
        chk("rmid_rsp0_result", 32'(rsp_result), 32'h000F);
        step();
        chk("rmid_second_grant", 32'(req_ready), 32'h8);
        step();
        req_valid[3] = 1'b0;
        step();
        step();
        chk("rmid_rsp3_valid", 32'(rsp_valid), 32'h8);
        chk("rmid_rsp3_result", 32'(rsp_result), 32'h0012);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
